// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arm_ctrl_pkg : state, mux-select, ALU and condition codes            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package arm_ctrl_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

endpackage
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cond_check : NZCV flag registers, condition evaluation, cond_ex_q    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cond_check
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       decode_i,
  output logic       cond_ex_o
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_now;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_now = 1'b1;
    case (cond_i)
      COND_EQ: cond_now = z;
      COND_NE: cond_now = ~z;
      COND_CS: cond_now = c;
      COND_CC: cond_now = ~c;
      COND_MI: cond_now = n;
      COND_PL: cond_now = ~n;
      COND_VS: cond_now = v;
      COND_VC: cond_now = ~v;
      COND_HI: cond_now = c & ~z;
      COND_LS: cond_now = ~c | z;
      COND_GE: cond_now = (n == v);
      COND_LT: cond_now = (n != v);
      COND_GT: cond_now = ~z & (n == v);
      COND_LE: cond_now = z | (n != v);
      default: cond_now = 1'b1;
    endcase
  end

  // flag_w_i is only non-zero in the execute states, so no state check here
  always_comb begin
    flags_d = flags_q;
    if (cond_ex_q && flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
    if (cond_ex_q && flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];
    cond_ex_d = decode_i ? cond_now : cond_ex_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= FLAGS_RST;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign cond_ex_o = cond_ex_q;

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_control_fsm : multicycle ARM control unit (sequencer + decoders)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mc_control_fsm
  import arm_ctrl_pkg::*;
#(
  parameter int         STATE_W   = 4,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] State
);

  state_t     state_q, state_d;
  logic [1:0] op;
  logic       funct5, funct0, s_bit;
  logic [3:0] cmd, rd;
  logic       next_pc, ir_write, reg_w, mem_w, branch, alu_op;
  logic [2:0] dec_ctl;
  logic [1:0] dec_fw, flag_w;
  logic       no_write, cond_ex;
  logic       unused_instr;

  assign op           = Instr[27:26];
  assign funct5       = Instr[25];
  assign cmd          = Instr[24:21];
  assign funct0       = Instr[20];
  assign s_bit        = Instr[20];
  assign rd           = Instr[15:12];
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    next_pc   = 1'b0;
    ir_write  = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1; next_pc = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct5 ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = funct0 ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1; state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA; reg_w = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1; mem_w = 1'b1;
      end
      S_EXECUTER: begin
        alu_op = 1'b1; state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB = SRCB_IMM; alu_op = 1'b1; state_d = S_ALUWB;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB = SRCB_IMM; ResultSrc = RES_ALURESULT; branch = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NoWrite is decoded from the instruction alone so it still applies in ALUWB
  always_comb begin
    dec_ctl  = ALU_ADD;
    dec_fw   = 2'b00;
    no_write = 1'b0;
    case (cmd)
      4'b0100: begin dec_ctl = ALU_ADD; dec_fw = {2{s_bit}}; end
      4'b0010: begin dec_ctl = ALU_SUB; dec_fw = {2{s_bit}}; end
      4'b0000: begin dec_ctl = ALU_AND; dec_fw = {s_bit, 1'b0}; end
      4'b1100: begin dec_ctl = ALU_ORR; dec_fw = {s_bit, 1'b0}; end
      4'b0001: begin dec_ctl = ALU_EOR; dec_fw = {s_bit, 1'b0}; end
      4'b1010: begin
        no_write = 1'b1;
        if (s_bit) begin dec_ctl = ALU_SUB; dec_fw = 2'b11; end
      end
      default: no_write = 1'b1;
    endcase
    if (op != 2'b00) no_write = 1'b0;
  end

  assign ALUControl = alu_op ? dec_ctl : ALU_ADD;
  assign flag_w     = alu_op ? dec_fw  : 2'b00;
  assign ImmSrc     = op;
  assign RegSrc     = {(op == 2'b01) & ~funct0, (op == 2'b10)};

  cond_check #(.FLAGS_RST(FLAGS_RST)) u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (Instr[31:28]),
    .alu_flags_i (ALUFlags),
    .flag_w_i    (flag_w),
    .decode_i    (state_q == S_DECODE),
    .cond_ex_o   (cond_ex)
  );

  assign RegWrite = ~reset & reg_w & cond_ex & ~no_write;
  assign MemWrite = ~reset & mem_w & cond_ex;
  assign IRWrite  = ~reset & ir_write;
  assign PCWrite  = ~reset & (next_pc | (cond_ex & (branch | (reg_w & (rd == 4'hF)))));
  assign State    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_control_fsm : directed + random instruction stream vs model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mc_control_fsm;
  import arm_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] m_flags;

  mc_control_fsm #(.STATE_W(4), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return c[0] ? !r : r;
  endfunction

  // ALU operation, whether the result reaches the register file, and which flags it sets
  function automatic void dp_decode(input logic [31:0] ins, output logic [2:0] ctl,
                                    output bit wr, output logic [3:0] mask);
    logic [3:0] cmd;
    bit s;
    cmd = ins[24:21]; s = ins[20];
    ctl = 3'd0; wr = 1'b1; mask = 4'h0;
    if (cmd == 4'b0100)      begin ctl = 3'd0; mask = s ? 4'hF : 4'h0; end
    else if (cmd == 4'b0010) begin ctl = 3'd1; mask = s ? 4'hF : 4'h0; end
    else if (cmd == 4'b0000) begin ctl = 3'd2; mask = s ? 4'hC : 4'h0; end
    else if (cmd == 4'b1100) begin ctl = 3'd3; mask = s ? 4'hC : 4'h0; end
    else if (cmd == 4'b0001) begin ctl = 3'd4; mask = s ? 4'hC : 4'h0; end
    else if (cmd == 4'b1010 && s) begin ctl = 3'd1; wr = 1'b0; mask = 4'hF; end
    else wr = 1'b0;
  endfunction

  // flags_force < 0 : random ALUFlags; rst_at >= 0 : assert reset in that cycle
  task automatic run_instr(input logic [31:0] ins, input int flags_force, input int rst_at);
    state_t     path[$];
    logic [1:0] op;
    bit         ce, wr, rd15, was_rst;
    logic [2:0] ctl;
    logic [3:0] mask;
    logic [3:0] exp_wen;
    logic [5:0] exp_mux;
    logic [2:0] exp_ctl;
    op   = ins[27:26];
    ce   = cond_true(ins[31:28], m_flags);
    rd15 = (ins[15:12] == 4'hF);
    dp_decode(ins, ctl, wr, mask);
    path = '{S_FETCH, S_DECODE};
    if (op == 2'b01) begin
      path.push_back(S_MEMADR);
      if (ins[20]) begin path.push_back(S_MEMREAD); path.push_back(S_MEMWB); end
      else path.push_back(S_MEMWRITE);
    end else if (op == 2'b00) begin
      path.push_back(ins[25] ? S_EXECUTEI : S_EXECUTER);
      path.push_back(S_ALUWB);
    end else if (op == 2'b10) begin
      path.push_back(S_BRANCH);
    end
    was_rst = 1'b0;
    for (int k = 0; k < path.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin reset = 1'b0; Instr = ins; end
      ALUFlags = (flags_force < 0) ? 4'($urandom) : 4'(flags_force);
      if (k == rst_at) reset = 1'b1;
      #1;
      exp_wen = 4'b0000; exp_mux = 6'b0; exp_ctl = 3'd0;
      // {PCWrite,MemWrite,RegWrite,IRWrite} and {AdrSrc,ALUSrcA,ALUSrcB,ResultSrc}
      case (path[k])
        S_FETCH:    begin exp_wen = 4'b1001; exp_mux = 6'b0_1_10_10; end
        S_DECODE:   exp_mux = 6'b0_1_10_10;
        S_MEMADR:   exp_mux = 6'b0_0_01_00;
        S_MEMREAD:  exp_mux = 6'b1_0_00_00;
        S_MEMWB:    begin exp_wen = {ce && rd15, 1'b0, ce, 1'b0}; exp_mux = 6'b0_0_00_01; end
        S_MEMWRITE: begin exp_wen = {1'b0, ce, 2'b00}; exp_mux = 6'b1_0_00_00; end
        S_EXECUTER: begin exp_ctl = ctl; exp_mux = 6'b0_0_00_00; end
        S_EXECUTEI: begin exp_ctl = ctl; exp_mux = 6'b0_0_01_00; end
        S_ALUWB:    exp_wen = {ce && rd15, 1'b0, ce && wr, 1'b0};
        S_BRANCH:   begin exp_wen = {ce, 3'b000}; exp_mux = 6'b0_0_01_10; end
        default:    ;
      endcase
      if (reset) exp_wen = 4'b0000;
      check_value("state", 32'(State), 32'(path[k]));
      check_value("write_enables", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'(exp_wen));
      check_value("mux_selects", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}), 32'(exp_mux));
      check_value("decode", 32'({ImmSrc, RegSrc, ALUControl}),
                  32'({op, (op == 2'b01) && !ins[20], op == 2'b10, exp_ctl}));
      @(posedge clk);
      if (reset) begin
        m_flags = 4'b0000; was_rst = 1'b1;
        break;
      end
      if ((path[k] == S_EXECUTER || path[k] == S_EXECUTEI) && ce)
        m_flags = (m_flags & ~mask) | (ALUFlags & mask);
    end
    #1;
    check_value("nzcv", 32'(dut.u_cond.flags_q), 32'(m_flags));
    if (was_rst) check_value("state_after_reset", 32'(State), 32'(S_FETCH));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    ins[31:28] = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
    ins[27:26] = 2'($urandom_range(0, 3));
    if (ins[27:26] == 2'b00) begin
      case ($urandom_range(0, 6))
        0: ins[24:21] = 4'b0100;
        1: ins[24:21] = 4'b0010;
        2: ins[24:21] = 4'b0000;
        3: ins[24:21] = 4'b1100;
        4: ins[24:21] = 4'b0001;
        5: ins[24:21] = 4'b1010;
        default: ins[24:21] = 4'($urandom);
      endcase
    end
    if ($urandom_range(0, 7) == 0) ins[15:12] = 4'hF;
    return ins;
  endfunction

  initial begin
    reset = 1'b1; Instr = 32'h0; ALUFlags = 4'h0; m_flags = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_value("reset_state", 32'(State), 32'(S_FETCH));
    check_value("reset_enables", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
    check_value("reset_nzcv", 32'(dut.u_cond.flags_q), 32'd0);

    run_instr(32'hE0821003, -1, -1);   // ADD R1,R2,R3
    run_instr(32'hE5904008, -1, -1);   // LDR R4,[R0,#8]
    run_instr(32'hE0500000,  4, -1);   // SUBS R0,R0,R0 -> Z
    run_instr(32'h0A000002, -1, -1);   // BEQ taken
    run_instr(32'h1A000002, -1, -1);   // BNE not taken
    run_instr(32'hE3510005,  0, -1);   // CMP R1,#5 -> clears Z
    run_instr(32'h05801000, -1, -1);   // STREQ skipped
    run_instr(32'hE080F001, -1, -1);   // ADD PC,R0,R1
    run_instr(32'hE0500000,  4, -1);   // set Z again before reset test
    run_instr(32'hE5904008, -1,  3);   // reset during MEMREAD
    run_instr(32'h0A000002, -1, -1);   // BEQ now sees cleared flags

    for (int i = 0; i < 400; i++) begin
      run_instr(rand_instr(), -1,
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
